shift_pattern_monitor: RTL and testbench
========================================

# shift_pattern_monitor

Receive-side checker for the 8-bit one-hot ping-pong shift pattern produced by our shift counter. The pattern is 0x01→0x02→…→0x80→0x40→…→0x01→0x02…, with a period of 14 and each endpoint appearing once per turn. The block samples the pattern, acquires lock, and decodes the current bit position and direction. It flags every deviation, flywheels through isolated glitches, and drops lock after repeated misses. It sits between the pattern source (or a pin/bus carrying it) and status/debug logic.

## Interface
- LOCK_LEN, 2, consecutive legal transitions required in ACQ before asserting lock (1..7)
- MISS_LIMIT, 3, consecutive mismatches in LOCKED that force return to HUNT (1..7)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state immediately
- pattern  input  8  observed shift pattern
- pattern_valid  input  1  pattern is sampled only on edges where this is 1
- pos  output  3  decoded bit index of the last accepted or predicted sample
- dir  output  1  direction of the last transition (0 = toward bit 7, 1 = toward bit 0)
- locked  output  1  monitor is in LOCKED
- err  output  1  one-cycle pulse: mismatch detected in LOCKED
- err_count  output  8  total mismatches in LOCKED, saturating at 255

## Operation
- One-hot means exactly one bit of pattern is set. The index of a one-hot sample is idx.
- Only edges with pattern_valid=1 advance anything. With pattern_valid=0, all state holds and err=0.
- States: HUNT, ACQ, LOCKED. Reset state is HUNT.
- HUNT:
  - One-hot sample: pos←idx, good←0, go to ACQ.
  - Non-one-hot sample: stay in HUNT. No err.
- ACQ:
  - A sample is legal if it is one-hot and |idx−pos|=1.
  - Legal sample: dir←(idx<pos), pos←idx, good←good+1. When good reaches LOCK_LEN, go to LOCKED with miss←0.
  - Illegal one-hot sample: pos←idx, good←0, stay in ACQ.
  - Non-one-hot sample: go to HUNT.
  - No err in ACQ.
- Prediction from (pos, dir):
  - dir=0, pos<7: expect pos+1, dir 0.
  - dir=0, pos=7: expect 6, dir 1.
  - dir=1, pos>0: expect pos−1, dir 1.
  - dir=1, pos=0: expect 1, dir 0.
- LOCKED:
  - Match (sample equals 1<<expected): pos/dir←predicted, miss←0.
  - Mismatch (including non-one-hot or all-zero): err pulses, err_count←min(err_count+1, 255), miss←miss+1. pos/dir still advance to the prediction (flywheel).
  - If miss reaches MISS_LIMIT: go to HUNT, locked←0. The err pulse for that sample still occurs.
- err_count is never cleared except by reset. It is counted only in LOCKED.

## Timing
- All outputs are registered. The response to a sample taken at edge N is visible after edge N and stays stable until the next valid edge.
- Lock latency from reset with an ideal stream: 1 + LOCK_LEN valid samples. locked goes high after the edge of the (LOCK_LEN+1)th sample.
- err is high for exactly one cycle after the mismatching edge. If a second valid mismatch arrives on the next edge, err stays high for that cycle too.
- Reset values: pos=0, dir=0, locked=0, err=0, err_count=0, state HUNT, good=0, miss=0.
- Asserting reset mid-operation clears everything asynchronously, without waiting for a clock edge. The first valid sample after release is treated as in HUNT.
- Endpoint turn: a 0x80 sample with dir=0 is accepted with dir still 0. The following 0x40 sets dir=1. This is symmetric at 0x01.
- A saturated err_count still produces the err pulse.

## Test plan
- Reset, then pattern 0x01,0x02,0x04,… every cycle with valid=1 → locked=1 after the 3rd edge with pos=2, dir=0. Over 28 further cycles, pos tracks exactly and err never fires.
- Locked stream …0x20,0x40,0x80,0x40,0x20 → pos 5,6,7,6,5; dir 0,0,0,1,1; no err. The mirror case at 0x02,0x01,0x02 gives dir 1,1,0.
- Locked at pos=3, dir=0; feed 0x18, then 0x20 → err pulse once, err_count=1, pos=4 after the glitch, pos=5 after 0x20, locked stays 1.
- Locked at pos=3, dir=0; feed 0x00 three times → err pulses three cycles, err_count=3, locked=0 after the 3rd edge. A subsequent 0x01,0x02,0x04 re-locks.
- Toggle pattern_valid: valid=0 cycles carrying 0xFF are interleaved within a locked stream → no err, pos only changes on valid edges.
- Async reset asserted between edges while locked with err_count=5 → all outputs are 0 before the next rising edge. Separately, 256+ alternating mismatch/match samples drive err_count to 255 and hold it there while err keeps pulsing.

Source files
------------

// File: rtl/shift_pattern_monitor.sv
// Purpose: lock onto the 8-bit one-hot ping-pong shift pattern, decode position/direction, flag deviations.
// Latency: all outputs registered; the response to a valid sample appears one clk after its edge.
// Backpressure: none; pattern_valid=0 edges freeze all state and leave err low.
module shift_pattern_monitor #(
  parameter int LOCK_LEN   = 2,
  parameter int MISS_LIMIT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pattern,
  input  logic       pattern_valid,
  output logic [2:0] pos,
  output logic       dir,
  output logic       locked,
  output logic       err,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {HUNT, ACQ, LOCKED} state_t;

  localparam logic [2:0] LOCK_LEN_C   = 3'(LOCK_LEN);
  localparam logic [2:0] MISS_LIMIT_C = 3'(MISS_LIMIT);

  state_t     state;
  logic [2:0] good;
  logic [2:0] miss;

  logic       is_onehot;
  logic [2:0] idx;
  logic       adjacent;
  logic [2:0] pred_pos;
  logic       pred_dir;
  logic       match;

  // Classify the sample: exactly one bit set, and which bit it is.
  always_comb begin
    is_onehot = (pattern != 8'd0) && ((pattern & (pattern - 8'd1)) == 8'd0);
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (pattern[i]) idx = 3'(i);
    end
  end

  // Neighbouring-bit test used during acquisition (widened so 7+1 cannot wrap to 0).
  always_comb begin
    adjacent = ({1'b0, idx} == {1'b0, pos} + 4'd1) ||
               ({1'b0, pos} == {1'b0, idx} + 4'd1);
  end

  // Next expected position/direction, bouncing off both endpoints.
  always_comb begin
    pred_pos = pos;
    pred_dir = dir;
    if (!dir) begin
      if (pos != 3'd7) begin
        pred_pos = pos + 3'd1;
        pred_dir = 1'b0;
      end else begin
        pred_pos = 3'd6;
        pred_dir = 1'b1;
      end
    end else begin
      if (pos != 3'd0) begin
        pred_pos = pos - 3'd1;
        pred_dir = 1'b1;
      end else begin
        pred_pos = 3'd1;
        pred_dir = 1'b0;
      end
    end
    match = (pattern == (8'd1 << pred_pos));
  end

  // Monitor FSM: hunt for a one-hot sample, count legal steps to lock, then track and flywheel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= HUNT;
      pos       <= 3'd0;
      dir       <= 1'b0;
      good      <= 3'd0;
      miss      <= 3'd0;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_count <= 8'd0;
    end else begin
      err <= 1'b0;
      if (pattern_valid) begin
        case (state)
          HUNT: begin
            if (is_onehot) begin
              pos   <= idx;
              good  <= 3'd0;
              state <= ACQ;
            end
          end
          ACQ: begin
            if (!is_onehot) begin
              state <= HUNT;
            end else if (adjacent) begin
              dir  <= (idx < pos);
              pos  <= idx;
              good <= good + 3'd1;
              if (good + 3'd1 == LOCK_LEN_C) begin
                state  <= LOCKED;
                locked <= 1'b1;
                miss   <= 3'd0;
              end
            end else begin
              // One-hot but not a neighbour: restart the count from this sample.
              pos  <= idx;
              good <= 3'd0;
            end
          end
          LOCKED: begin
            // Position always advances to the prediction so a single glitch does not desync us.
            pos <= pred_pos;
            dir <= pred_dir;
            if (match) begin
              miss <= 3'd0;
            end else begin
              err  <= 1'b1;
              miss <= miss + 3'd1;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
              if (miss + 3'd1 == MISS_LIMIT_C) begin
                state  <= HUNT;
                locked <= 1'b0;
              end
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_shift_pattern_monitor.sv
// Purpose: self-checking bench for shift_pattern_monitor against a phase-based reference model.
// Latency: outputs compared 1 time unit after every rising edge.
// Backpressure: bench drives pattern_valid low on selected cycles to check that state freezes.
module tb_shift_pattern_monitor;

  localparam int LOCK_LEN   = 2;
  localparam int MISS_LIMIT = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pattern = 8'd0;
  logic       pattern_valid = 1'b0;
  logic [2:0] pos;
  logic       dir;
  logic       locked;
  logic       err;
  logic [7:0] err_count;

  int tests = 0;
  int fails = 0;

  shift_pattern_monitor #(.LOCK_LEN(LOCK_LEN), .MISS_LIMIT(MISS_LIMIT)) dut (
    .clk(clk), .reset(reset), .pattern(pattern), .pattern_valid(pattern_valid),
    .pos(pos), .dir(dir), .locked(locked), .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // Reference model. The locked pattern is tracked as a phase 0..13 around the
  // 14-step ping-pong cycle; position and direction are derived from the phase.
  int mmode;   // 0 hunt, 1 acquire, 2 locked
  int mpos, mgood, mmiss, mphase, mcnt;
  bit mdir, merr;

  function automatic int ph_pos(input int ph);
    return (ph <= 7) ? ph : 14 - ph;
  endfunction

  function automatic bit ph_dir(input int ph);
    return (ph == 0) || (ph >= 8);
  endfunction

  function automatic int oh_idx(input logic [7:0] p);
    if ($countones(p) != 1) return -1;
    for (int i = 0; i < 8; i++) if (p[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    mmode = 0; mpos = 0; mdir = 0; mgood = 0; mmiss = 0; mphase = 0; mcnt = 0; merr = 0;
  endtask

  task automatic model_step(input logic [7:0] p, input logic v);
    int id;
    merr = 0;
    if (!v) return;
    id = oh_idx(p);
    if (mmode == 0) begin
      if (id >= 0) begin mpos = id; mgood = 0; mmode = 1; end
    end else if (mmode == 1) begin
      if (id < 0) mmode = 0;
      else if (id == mpos + 1 || id == mpos - 1) begin
        mdir = (id < mpos); mpos = id; mgood++;
        if (mgood == LOCK_LEN) begin
          mmode = 2; mmiss = 0;
          mphase = mdir ? ((mpos == 0) ? 0 : 14 - mpos) : mpos;
        end
      end else begin
        mpos = id; mgood = 0;
      end
    end else begin
      mphase = (mphase + 1) % 14;
      mpos = ph_pos(mphase);
      mdir = ph_dir(mphase);
      if (p == (8'h01 << mpos)) mmiss = 0;
      else begin
        merr = 1;
        if (mcnt < 255) mcnt++;
        mmiss++;
        if (mmiss == MISS_LIMIT) mmode = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pos", {5'd0, pos}, 8'(mpos));
    chk("dir", {7'd0, dir}, {7'd0, mdir});
    chk("locked", {7'd0, locked}, (mmode == 2) ? 8'd1 : 8'd0);
    chk("err", {7'd0, err}, {7'd0, merr});
    chk("err_count", err_count, 8'(mcnt));
  endtask

  task automatic step(input logic [7:0] p, input logic v);
    pattern = p;
    pattern_valid = v;
    @(posedge clk);
    model_step(p, v);
    #1;
    check_all();
  endtask

  // Synchronous-looking reset sequence between sections.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  int sp;
  int r;
  logic [7:0] rp;
  logic rv;

  initial begin
    model_reset();
    #2;
    chk("reset_pos", {5'd0, pos}, 8'd0);
    chk("reset_locked", {7'd0, locked}, 8'd0);
    chk("reset_cnt", err_count, 8'd0);
    @(negedge clk);
    reset = 1'b0;

    // Ideal stream from reset: lock after the third edge, then track through both turns.
    for (int k = 0; k < 31; k++) begin
      step(8'h01 << ph_pos(k % 14), 1'b1);
      if (k == 2) begin
        chk("lock_after_3", {7'd0, locked}, 8'd1);
        chk("lock_pos", {5'd0, pos}, 8'd2);
      end
      if (k == 7)  chk("turn80_dir", {7'd0, dir}, 8'd0);
      if (k == 8)  chk("turn40_dir", {7'd0, dir}, 8'd1);
      if (k == 14) chk("turn01_dir", {7'd0, dir}, 8'd1);
      if (k == 15) chk("turn02_dir", {7'd0, dir}, 8'd0);
    end

    // Single glitch at pos 3 flywheels through.
    do_reset();
    step(8'h01, 1'b1); step(8'h02, 1'b1); step(8'h04, 1'b1); step(8'h08, 1'b1);
    step(8'h18, 1'b1);
    chk("glitch_err", {7'd0, err}, 8'd1);
    chk("glitch_pos", {5'd0, pos}, 8'd4);
    step(8'h20, 1'b1);
    chk("glitch_cnt", err_count, 8'd1);
    chk("glitch_locked", {7'd0, locked}, 8'd1);
    chk("glitch_pos2", {5'd0, pos}, 8'd5);

    // Three zero samples drop lock; stream re-locks afterwards.
    do_reset();
    step(8'h01, 1'b1); step(8'h02, 1'b1); step(8'h04, 1'b1); step(8'h08, 1'b1);
    step(8'h00, 1'b1); step(8'h00, 1'b1); step(8'h00, 1'b1);
    chk("miss_unlock", {7'd0, locked}, 8'd0);
    chk("miss_cnt", err_count, 8'd3);
    step(8'h01, 1'b1); step(8'h02, 1'b1); step(8'h04, 1'b1);
    chk("relock", {7'd0, locked}, 8'd1);

    // Invalid cycles carrying 0xFF interleaved within a locked stream.
    do_reset();
    sp = 0;
    for (int k = 0; k < 40; k++) begin
      if (k % 3 == 2) step(8'hFF, 1'b0);
      else begin
        step(8'h01 << ph_pos(sp), 1'b1);
        sp = (sp + 1) % 14;
      end
    end

    // Build err_count to 5 with alternating mismatch/match, then reset between edges.
    do_reset();
    step(8'h01, 1'b1); step(8'h02, 1'b1); step(8'h04, 1'b1);
    sp = 2;
    for (int k = 0; k < 5; k++) begin
      sp = (sp + 1) % 14; step(8'h00, 1'b1);
      sp = (sp + 1) % 14; step(8'h01 << ph_pos(sp), 1'b1);
    end
    chk("pre_reset_cnt", err_count, 8'd5);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_pos", {5'd0, pos}, 8'd0);
    chk("async_locked", {7'd0, locked}, 8'd0);
    chk("async_cnt", err_count, 8'd0);
    check_all();
    @(negedge clk);
    reset = 1'b0;

    // Saturation: alternating mismatch/match keeps lock while err_count climbs to 255.
    step(8'h01, 1'b1); step(8'h02, 1'b1); step(8'h04, 1'b1);
    sp = 2;
    for (int k = 0; k < 260; k++) begin
      sp = (sp + 1) % 14; step(8'h00, 1'b1);
      sp = (sp + 1) % 14; step(8'h01 << ph_pos(sp), 1'b1);
    end
    chk("sat_cnt", err_count, 8'd255);
    step(8'h00, 1'b1);
    chk("sat_err", {7'd0, err}, 8'd1);
    chk("sat_cnt2", err_count, 8'd255);

    // Randomized stream with glitches, skips, garbage and invalid cycles.
    do_reset();
    sp = 0;
    for (int k = 0; k < 2000; k++) begin
      rv = ($urandom % 5) != 0;
      r  = $urandom % 16;
      if (!rv)        rp = 8'hFF;
      else if (r == 0) rp = 8'($urandom);
      else if (r == 1) rp = 8'h00;
      else if (r == 2) begin sp = (sp + 1) % 14; rp = 8'h01 << ph_pos(sp); end
      else            rp = 8'h01 << ph_pos(sp);
      step(rp, rv);
      if (rv) sp = (sp + 1) % 14;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
